// File: rtl/mem_pkg.sv
// Shared types for the memory response controller: FSM states, wait-counter width,
// error codes and the latched transaction payload.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ALIGN    = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_t;

    typedef struct packed {
        logic              port_d;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    // Conflicting ops take priority, then alignment, then range.
    function automatic err_t classify(input logic [ADDR_W-1:0] addr,
                                      input logic rd,
                                      input logic wr,
                                      input int unsigned depth);
        err_t res;
        res = ERR_NONE;
        if (rd && wr) begin
            res = ERR_CONFLICT;
        end else if (addr[1:0] != 2'b00) begin
            res = ERR_ALIGN;
        end else if ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth)) begin
            res = ERR_RANGE;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 32 storage: synchronous write, combinational read, no reset.
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp_ctrl.sv
// Two-port (instruction/data) memory front end: one transaction in flight,
// fixed wait states, single-cycle completion pulse with error flag.
module mem_resp_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_ler,
    input  logic [31:0] i_end,
    output logic [31:0] i_dado,
    output logic        i_pronto,
    input  logic        d_ler,
    input  logic        d_esc,
    input  logic [31:0] d_end,
    input  logic [31:0] d_wdado,
    output logic [31:0] d_rdado,
    output logic        d_pronto,
    output logic        erro
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    txn_t             txn_q, txn_in, cur;
    logic             pending, load, enter_resp, mem_we;
    err_t             err_c;
    logic [31:0]      mem_rdata;

    // Arbitration: the data port wins when both ports are requesting.
    always_comb begin
        txn_in        = '0;
        txn_in.port_d = d_ler | d_esc;
        txn_in.wdata  = d_wdado;
        if (txn_in.port_d) begin
            txn_in.rd   = d_ler;
            txn_in.wr   = d_esc;
            txn_in.addr = d_end;
        end else begin
            txn_in.rd   = i_ler;
            txn_in.wr   = 1'b0;
            txn_in.addr = i_end;
        end
    end

    assign pending = d_ler | d_esc | i_ler;

    // In IDLE the live request is what gets accepted (matters when WAIT_CYC is 0).
    assign cur   = (state_q == IDLE) ? txn_in : txn_q;
    assign err_c = classify(cur.addr, cur.rd, cur.wr, DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                txn_q <= txn_in;
            end
        end
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    // Gated by reset so a held-low reset can never commit a write.
    assign mem_we     = reset_n && enter_resp && cur.port_d && cur.wr && (err_c == ERR_NONE);

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (cur.addr[AW+1:2]),
        .wdata (cur.wdata),
        .rdata (mem_rdata)
    );

    // Completion outputs are loaded on the edge entering RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_pronto <= 1'b0;
            d_pronto <= 1'b0;
            erro     <= 1'b0;
            i_dado   <= '0;
            d_rdado  <= '0;
        end else begin
            i_pronto <= enter_resp && !cur.port_d;
            d_pronto <= enter_resp && cur.port_d;
            erro     <= enter_resp && (err_c != ERR_NONE);
            if (enter_resp && !cur.port_d) begin
                i_dado <= (err_c == ERR_NONE) ? mem_rdata : 32'h0;
            end
            if (enter_resp && cur.port_d && (cur.rd || (err_c != ERR_NONE))) begin
                d_rdado <= (err_c == ERR_NONE) ? mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: doc/mem_resp_ctrl.md
MEM_RESP_CTRL -- requirements
Module: mem_resp_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning wait-state cycles per access (range 0..15).
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ler  input  1  instruction-port read request, held until i_pronto.
REQ-006 SHALL have port i_end  input  32  instruction-port byte address.
REQ-007 SHALL have port i_dado  output  32  instruction-port read data.
REQ-008 SHALL have port i_pronto  output  1  instruction-port completion pulse.
REQ-009 SHALL have port d_ler  input  1  data-port read request.
REQ-010 SHALL have port d_esc  input  1  data-port write request.
REQ-011 SHALL have port d_end  input  32  data-port byte address.
REQ-012 SHALL have port d_wdado  input  32  data-port write data.
REQ-013 SHALL have port d_rdado  output  32  data-port read data.
REQ-014 SHALL have port d_pronto  output  1  data-port completion pulse.
REQ-015 SHALL have port erro  output  1  error flag, valid with the pronto pulse it accompanies.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one transaction in flight at a time.
REQ-017 In IDLE, a pending request SHALL be accepted at the rising edge; data port wins over instruction port when both pending.
REQ-018 Port select, address, write data and op SHALL be latched at acceptance; later input changes SHALL be ignored.
REQ-019 IDLE->WAIT on acceptance; WAIT counts WAIT_CYC cycles then ->RESP; WAIT_CYC=0 SHALL go IDLE->RESP directly.
REQ-020 In RESP, exactly the selected port's pronto SHALL be high for one cycle, then ->IDLE.
REQ-021 Latency: pronto SHALL be high in cycle WAIT_CYC+1 after the acceptance edge.
REQ-022 Read data SHALL be valid on the selected port's data output during RESP and hold until that port's next completion.
REQ-023 A write SHALL commit to memory on the edge entering RESP, never earlier.
REQ-024 Requester SHALL deassert the request at the edge where pronto is sampled high; a request still high in IDLE is a new transaction.
REQ-025 Address bits [1:0] nonzero SHALL set erro in RESP; no write, read data 32'h0.
REQ-026 Word index (address>>2) >= DEPTH SHALL set erro; no write, read data 32'h0.
REQ-027 d_ler and d_esc both high at acceptance SHALL set erro; no memory access.
REQ-028 erro SHALL be low in all cycles outside RESP.

Reset
REQ-029 reset_n low SHALL force state IDLE, wait counter 0, i_pronto=0, d_pronto=0, erro=0, i_dado=0, d_rdado=0, asynchronously.
REQ-030 Reset during WAIT SHALL abandon the transaction; pending write SHALL NOT commit.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 State encoding, WAIT counter width and error-code constants SHALL reside in shared package mem_pkg.
REQ-033 Storage SHALL be a sub-module mem_array (single-port, synchronous write, DEPTH x 32).

Verification
REQ-034 Data write 32'hDEADBEEF @0x10, then instruction read @0x10 -> i_pronto at cycle 3 after acceptance, i_dado=32'hDEADBEEF, erro=0.
REQ-035 i_ler and d_ler asserted same cycle @0x0/0x4 -> data served first (d_pronto), instruction served next, never both pronto together.
REQ-036 d_esc @0x12 (misaligned) data 32'h1 -> erro=1 with d_pronto; subsequent read @0x10 returns prior contents unchanged.
REQ-037 d_ler @ (DEPTH*4) -> d_pronto, erro=1, d_rdado=32'h0.
REQ-038 d_esc 32'hCAFEF00D @0x20, reset_n pulsed low during WAIT -> all outputs 0, FSM IDLE; later read @0x20 returns old value.
REQ-039 WAIT_CYC=0 build: back-to-back reads held per REQ-024 -> pronto every second cycle, correct data each time.
